// File: rtl/debug_ram_loader.sv
// Byte-stream loader/dumper for the RV32Core debug RAM ports; holds the core in reset while loading.
// Define DBG_LOADER_CHECKSUM_EN to require an XOR checksum byte after the last word of each load.
module debug_ram_loader #(
   parameter int WORDS      = 4096,
   parameter int RST_CYCLES = 5
) (
   input  logic        CPU_CLK,
   input  logic        CPU_RST_N,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        out_valid,
   output logic [7:0]  out_data,
   input  logic        out_ready,
   output logic [31:0] CPU_Debug_DataRAM_A2,
   output logic [31:0] CPU_Debug_DataRAM_WD2,
   output logic [3:0]  CPU_Debug_DataRAM_WE2,
   input  logic [31:0] CPU_Debug_DataRAM_RD2,
   output logic [31:0] CPU_Debug_InstRAM_A2,
   output logic [31:0] CPU_Debug_InstRAM_WD2,
   output logic [3:0]  CPU_Debug_InstRAM_WE2,
   output logic        core_rst,
   output logic        busy,
   output logic        err
);

   localparam int IDXW = $clog2(WORDS + 1);
   localparam int RCW  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [16:0]    WORDS_L  = 17'(WORDS);
   localparam logic [RCW-1:0] RUN_LAST = RCW'(RST_CYCLES - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_CNT_LO,
      S_CNT_HI,
      S_LOAD_BYTE,
      S_LOAD_WRITE,
      S_CSUM,
      S_DUMP_ADDR,
      S_DUMP_WAIT,
      S_DUMP_SEND,
      S_RUN_PULSE
   } state_t;

   state_t           stateQ, stateD;
   logic             selDataQ, selDataD;
   logic             dumpQ, dumpD;
   logic [15:0]      cntQ, cntD;
   logic [IDXW-1:0]  idxQ, idxD;
   logic [1:0]       byteQ, byteD;
   logic [31:0]      wordQ, wordD;
   logic [RCW-1:0]   runCntQ, runCntD;
   logic             coreRstQ, coreRstD;
   logic             errQ, errD;
`ifdef DBG_LOADER_CHECKSUM_EN
   logic [7:0]       csumQ, csumD;
`endif

   logic        readyState;
   logic        accept;
   logic        lastWord;
   logic [15:0] newCnt;
   logic [31:0] wordAddr;
   logic        writeCycle;

   always_ff @(posedge CPU_CLK) begin
      if (!CPU_RST_N) begin
         stateQ   <= S_IDLE;
         selDataQ <= 1'b0;
         dumpQ    <= 1'b0;
         cntQ     <= '0;
         idxQ     <= '0;
         byteQ    <= '0;
         wordQ    <= '0;
         runCntQ  <= '0;
         coreRstQ <= 1'b1;
         errQ     <= 1'b0;
`ifdef DBG_LOADER_CHECKSUM_EN
         csumQ    <= '0;
`endif
      end else begin
         stateQ   <= stateD;
         selDataQ <= selDataD;
         dumpQ    <= dumpD;
         cntQ     <= cntD;
         idxQ     <= idxD;
         byteQ    <= byteD;
         wordQ    <= wordD;
         runCntQ  <= runCntD;
         coreRstQ <= coreRstD;
         errQ     <= errD;
`ifdef DBG_LOADER_CHECKSUM_EN
         csumQ    <= csumD;
`endif
      end
   end

   // Reset is gated in so the host never sees a ready handshake while the loader is held.
   always_comb begin
      readyState = (stateQ == S_IDLE) || (stateQ == S_CNT_LO) ||
                   (stateQ == S_CNT_HI) || (stateQ == S_LOAD_BYTE);
`ifdef DBG_LOADER_CHECKSUM_EN
      if (stateQ == S_CSUM) begin
         readyState = 1'b1;
      end
`endif
   end

   assign in_ready   = CPU_RST_N && readyState;
   assign accept     = in_valid && in_ready;
   assign newCnt     = {in_data, cntQ[7:0]};
   assign lastWord   = ({{(16-IDXW){1'b0}}, idxQ} == (cntQ - 16'd1));
   assign wordAddr   = {{(30-IDXW){1'b0}}, idxQ, 2'b00};
   assign writeCycle = (stateQ == S_LOAD_WRITE);

   always_comb begin
      stateD   = stateQ;
      selDataD = selDataQ;
      dumpD    = dumpQ;
      cntD     = cntQ;
      idxD     = idxQ;
      byteD    = byteQ;
      wordD    = wordQ;
      runCntD  = runCntQ;
      coreRstD = coreRstQ;
      errD     = errQ;
`ifdef DBG_LOADER_CHECKSUM_EN
      csumD    = csumQ;
`endif

      case (stateQ)
         S_IDLE: begin
            if (accept) begin
               case (in_data)
                  8'h01: begin
                     selDataD = 1'b0;
                     dumpD    = 1'b0;
                     coreRstD = 1'b1;
                     stateD   = S_CNT_LO;
                  end
                  8'h02: begin
                     selDataD = 1'b1;
                     dumpD    = 1'b0;
                     coreRstD = 1'b1;
                     stateD   = S_CNT_LO;
                  end
                  8'h03: begin
                     selDataD = 1'b1;
                     dumpD    = 1'b1;
                     stateD   = S_CNT_LO;
                  end
                  8'h04: begin
                     coreRstD = 1'b1;
                     runCntD  = '0;
                     stateD   = S_RUN_PULSE;
                  end
                  default: errD = 1'b1;
               endcase
            end
         end

         S_CNT_LO: begin
            if (accept) begin
               cntD   = {8'h00, in_data};
               stateD = S_CNT_HI;
            end
         end

         // Zero and oversized counts return to IDLE without touching either RAM.
         S_CNT_HI: begin
            if (accept) begin
               cntD  = newCnt;
               idxD  = '0;
               byteD = '0;
`ifdef DBG_LOADER_CHECKSUM_EN
               csumD = '0;
`endif
               if (newCnt == 16'd0) begin
                  stateD = S_IDLE;
               end else if ({1'b0, newCnt} > WORDS_L) begin
                  errD   = 1'b1;
                  stateD = S_IDLE;
               end else if (dumpQ) begin
                  stateD = S_DUMP_ADDR;
               end else begin
                  stateD = S_LOAD_BYTE;
               end
            end
         end

         S_LOAD_BYTE: begin
            if (accept) begin
               wordD[8*byteQ +: 8] = in_data;
               byteD = byteQ + 2'd1;
`ifdef DBG_LOADER_CHECKSUM_EN
               csumD = csumQ ^ in_data;
`endif
               if (byteQ == 2'd3) begin
                  stateD = S_LOAD_WRITE;
               end
            end
         end

         S_LOAD_WRITE: begin
            if (lastWord) begin
`ifdef DBG_LOADER_CHECKSUM_EN
               stateD = S_CSUM;
`else
               stateD = S_IDLE;
`endif
            end else begin
               idxD   = idxQ + 1'b1;
               stateD = S_LOAD_BYTE;
            end
         end

         S_CSUM: begin
`ifdef DBG_LOADER_CHECKSUM_EN
            if (accept) begin
               if (in_data != csumQ) begin
                  errD = 1'b1;
               end
               stateD = S_IDLE;
            end
`else
            stateD = S_IDLE;
`endif
         end

         S_DUMP_ADDR: stateD = S_DUMP_WAIT;

         // RD2 reflects the address presented during DUMP_ADDR one cycle later.
         S_DUMP_WAIT: begin
            wordD  = CPU_Debug_DataRAM_RD2;
            byteD  = '0;
            stateD = S_DUMP_SEND;
         end

         S_DUMP_SEND: begin
            if (out_ready) begin
               byteD = byteQ + 2'd1;
               if (byteQ == 2'd3) begin
                  if (lastWord) begin
                     stateD = S_IDLE;
                  end else begin
                     idxD   = idxQ + 1'b1;
                     stateD = S_DUMP_ADDR;
                  end
               end
            end
         end

         S_RUN_PULSE: begin
            if (runCntQ == RUN_LAST) begin
               coreRstD = 1'b0;
               stateD   = S_IDLE;
            end else begin
               runCntD = runCntQ + 1'b1;
            end
         end

         default: stateD = S_IDLE;
      endcase
   end

   assign CPU_Debug_InstRAM_A2  = wordAddr;
   assign CPU_Debug_InstRAM_WD2 = wordQ;
   assign CPU_Debug_InstRAM_WE2 = (writeCycle && !selDataQ) ? 4'hF : 4'h0;
   assign CPU_Debug_DataRAM_A2  = wordAddr;
   assign CPU_Debug_DataRAM_WD2 = wordQ;
   assign CPU_Debug_DataRAM_WE2 = (writeCycle && selDataQ) ? 4'hF : 4'h0;

   assign out_valid = (stateQ == S_DUMP_SEND);
   assign out_data  = out_valid ? wordQ[8*byteQ +: 8] : 8'h00;
   assign busy      = (stateQ != S_IDLE);
   assign core_rst  = coreRstQ;
   assign err       = errQ;

endmodule
